// File: rtl/dmem_bus_ctrl.sv
// M-stage data-memory controller: registers a load/store onto a req/ack bus and
// stalls the pipeline until the bus acknowledges or the request times out.
module dmem_bus_ctrl #(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadM,
    input  logic            MemWrite,
    input  logic [3:0]      MemWriteSelect,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MemStallM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bit              TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [31:0]     TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;
    localparam logic [XLEN-1:0] WORD_MASK    = {{(XLEN-2){1'b1}}, 2'b00};

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] count_reg;
    logic        access;
    logic        ack_hit;
    logic        timeout_hit;

    assign access = MemReadM | MemWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stall is masked during reset so an aborted request releases the core at once.
    always_comb begin
        state_next  = state_reg;
        MemStallM   = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                MemStallM = access & ~reset;
                if (access) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                MemStallM   = 1'b1;
                ack_hit     = bus_ack;
                timeout_hit = TIMEOUT_EN && !bus_ack && (count_reg == TIMEOUT_LAST);
                if (ack_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataM <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'h0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            count_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        // A simultaneous read+write is handled purely as a store.
                        bus_req   <= 1'b1;
                        bus_we    <= MemWrite;
                        bus_be    <= MemWrite ? MemWriteSelect : 4'hF;
                        bus_addr  <= ALUResultM & WORD_MASK;
                        bus_wdata <= WriteDataM;
                        count_reg <= 32'd0;
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            ReadDataM <= bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_we) begin
                            ReadDataM <= '0;
                        end
                    end else if (count_reg != 32'hFFFF_FFFF) begin
                        count_reg <= count_reg + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized accesses against a transaction-level reference model.
module tb_dmem_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWrite;
    logic [3:0]  MemWriteSelect;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int req_pulses = 0;
    logic prev_req = 1'b0;

    logic [31:0] model_rdm;
    logic        model_err;

    dmem_bus_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWrite(MemWrite), .MemWriteSelect(MemWriteSelect),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .MemStallM(MemStallM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_req <= bus_req;
        if (bus_req && !prev_req) req_pulses <= req_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_inputs();
        MemReadM = 0; MemWrite = 0; MemWriteSelect = 0;
        ALUResultM = 0; WriteDataM = 0; bus_ack = 0; bus_rdata = 0;
    endtask

    // Entered and left just after a rising edge. The bus side acks after 'delay' REQ cycles.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input int delay,
                             input logic [31:0] rdata, input logic [31:0] e_addr,
                             input logic [3:0] e_be, input logic e_we, input int e_stall,
                             input int e_reqc, input logic [31:0] e_rdm, input logic e_err);
        int  stallc = 0;
        int  reqc   = 0;
        bit  done   = 0;
        MemReadM = rd; MemWrite = wr; MemWriteSelect = sel;
        ALUResultM = addr; WriteDataM = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_ack   = bus_req && (reqc == delay);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
            if (bus_req) begin
                chk({tag, " addr"}, bus_addr, e_addr);
                chk({tag, " be"}, {28'd0, bus_be}, {28'd0, e_be});
                chk({tag, " we"}, {31'd0, bus_we}, {31'd0, e_we});
                chk({tag, " wdata"}, bus_wdata, wdata);
                reqc++;
            end
            if (MemStallM) begin
                stallc++;
            end else begin
                done = 1;
                chk({tag, " rdata"}, ReadDataM, e_rdm);
                chk({tag, " err"}, {31'd0, bus_err}, {31'd0, e_err});
                chk({tag, " req in done"}, {31'd0, bus_req}, 32'd0);
            end
            @(posedge clk); #1;
        end
        if (!done) chk({tag, " completion"}, 32'd0, 32'd1);
        chk({tag, " stall cycles"}, stallc, e_stall);
        chk({tag, " req cycles"}, reqc, e_reqc);
        drop_inputs();
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        int          e_stall;
        logic [31:0] e_rdm;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1, 0, 4'h0, 32'h104, 32'h0, 0, 32'hCAFEF00D,
                    32'h104, 4'hF, 0, 2, 32'hCAFEF00D};
        vecs[1] = '{0, 1, 4'h8, 32'h203, 32'hAB000000, 3, 32'h12345678,
                    32'h200, 4'h8, 1, 5, 32'hCAFEF00D};
        vecs[2] = '{1, 1, 4'h3, 32'h30A, 32'h0000BEEF, 1, 32'hDEADBEEF,
                    32'h308, 4'h3, 1, 3, 32'hCAFEF00D};
        vecs[3] = '{1, 0, 4'h5, 32'hFFFFFFFF, 32'h11111111, 2, 32'h0BADF00D,
                    32'hFFFFFFFC, 4'hF, 0, 4, 32'h0BADF00D};

        reset = 1;
        drop_inputs();
        #12;
        chk("reset stall", {31'd0, MemStallM}, 32'd0);
        chk("reset req", {31'd0, bus_req}, 32'd0);
        chk("reset rdata", ReadDataM, 32'd0);
        chk("reset be", {28'd0, bus_be}, 32'd0);
        chk("reset addr", bus_addr, 32'd0);
        chk("reset err", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].sel,
                      vecs[i].addr, vecs[i].wdata, vecs[i].delay, vecs[i].rdata,
                      vecs[i].e_addr, vecs[i].e_be, vecs[i].e_we, vecs[i].e_stall,
                      vecs[i].e_stall - 1, vecs[i].e_rdm, 1'b0);
        end

        // Back-to-back load then store: exactly two bus requests.
        begin
            int p0;
            p0 = req_pulses;
            do_access("b2b load", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h55AA55AA,
                      32'h80, 4'hF, 0, 3, 2, 32'h55AA55AA, 1'b0);
            do_access("b2b store", 0, 1, 4'hC, 32'h84, 32'hABCD0000, 0, 32'h0,
                      32'h84, 4'hC, 1, 2, 1, 32'h55AA55AA, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            chk("b2b pulses", req_pulses - p0, 32'd2);
        end

        // Never-acked load times out, then a following access still completes.
        do_access("timeout load", 1, 0, 4'h0, 32'h500, 32'h0, 99, 32'h0,
                  32'h500, 4'hF, 0, TO + 1, TO, 32'h0, 1'b1);
        do_access("after timeout", 1, 0, 4'h0, 32'h504, 32'h0, 0, 32'h600DF00D,
                  32'h504, 4'hF, 0, 2, 1, 32'h600DF00D, 1'b1);

        // Reset during the second REQ cycle.
        MemReadM = 1; ALUResultM = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst-req pre req", {31'd0, bus_req}, 32'd1);
        #2;
        reset = 1;
        #1;
        chk("rst-req req", {31'd0, bus_req}, 32'd0);
        chk("rst-req stall", {31'd0, MemStallM}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        drop_inputs();
        bus_ack = 1; bus_rdata = 32'h77777777;
        repeat (3) begin
            @(negedge clk);
            chk("rst-late ack req", {31'd0, bus_req}, 32'd0);
            chk("rst-late ack stall", {31'd0, MemStallM}, 32'd0);
            chk("rst-late ack rdata", ReadDataM, 32'd0);
            chk("rst-late ack err", {31'd0, bus_err}, 32'd0);
            @(posedge clk); #1;
        end
        bus_ack = 0;
        do_access("after reset", 1, 0, 4'h0, 32'h44, 32'h0, 1, 32'h13579BDF,
                  32'h44, 4'hF, 0, 3, 2, 32'h13579BDF, 1'b0);

        model_rdm = 32'h13579BDF;
        model_err = 1'b0;
        for (int n = 0; n < 200; n++) begin
            int          kind, delay, reqc;
            logic        rd, wr, timed;
            logic [3:0]  sel, be;
            logic [31:0] addr, wdata, rdata;
            kind  = $urandom_range(0, 2);
            rd    = (kind != 1);
            wr    = (kind != 0);
            sel   = 4'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            delay = $urandom_range(0, TO + 1);
            timed = (delay >= TO);
            reqc  = timed ? TO : delay + 1;
            be    = wr ? sel : 4'hF;
            if (!wr) model_rdm = timed ? 32'h0 : rdata;
            model_err = model_err | timed;
            do_access($sformatf("rnd%0d", n), rd, wr, sel, addr, wdata, delay, rdata,
                      {addr[31:2], 2'b00}, be, wr, reqc + 1, reqc, model_rdm, model_err);
            repeat ($urandom_range(0, 2)) begin
                bus_ack = 1'($urandom);
                bus_rdata = $urandom;
                @(negedge clk);
                chk("idle stall", {31'd0, MemStallM}, 32'd0);
                chk("idle req", {31'd0, bus_req}, 32'd0);
                chk("idle rdata", ReadDataM, model_rdm);
                @(posedge clk); #1;
            end
            bus_ack = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
